// File: rtl/mac_sched.sv
// mac_sched: round-robin arbiter that lets two requesters take turns at one
// shared signed multiplier. Each requester streams a vector of operand pairs.
// The block accumulates the products into a saturating accumulator and
// returns the dot product tagged with the requester ID.
// The multiplier is outside this block: O_MUL_IN1/2 go out, and I_MUL_OUT
// comes back combinationally in the same cycle.
module mac_sched #(
    parameter int INWL  = 8,
    parameter int ACCWL = 20
) (
    input  logic                I_CLK,
    input  logic                I_RST_N,
    input  logic                I_REQ0_VALID,
    input  logic [INWL-1:0]     I_REQ0_IN1,
    input  logic [INWL-1:0]     I_REQ0_IN2,
    input  logic                I_REQ0_LAST,
    output logic                O_REQ0_READY,
    input  logic                I_REQ1_VALID,
    input  logic [INWL-1:0]     I_REQ1_IN1,
    input  logic [INWL-1:0]     I_REQ1_IN2,
    input  logic                I_REQ1_LAST,
    output logic                O_REQ1_READY,
    output logic [INWL-1:0]     O_MUL_IN1,
    output logic [INWL-1:0]     O_MUL_IN2,
    input  logic [2*INWL-1:0]   I_MUL_OUT,
    output logic                O_RES_VALID,
    output logic [ACCWL-1:0]    O_RES_DATA,
    output logic                O_RES_ID,
    output logic                O_RES_SAT,
    input  logic                I_RES_READY,
    output logic                O_BUSY
);

    // Number of sign bits needed to widen the product to the ACCWL+1 sum width.
    localparam int EXTW = ACCWL + 1 - 2 * INWL;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Clamp an ACCWL+1 bit sum into ACCWL bits. It returns max positive or
    // max negative when the two top bits disagree.
    function automatic logic [ACCWL-1:0] clamp_sum(input logic [ACCWL:0] sum);
        logic [ACCWL-1:0] res;
        if (sum[ACCWL] != sum[ACCWL-1]) begin
            if (sum[ACCWL]) begin
                res = {1'b1, {(ACCWL-1){1'b0}}};
            end else begin
                res = {1'b0, {(ACCWL-1){1'b1}}};
            end
        end else begin
            res = sum[ACCWL-1:0];
        end
        return res;
    endfunction

    // Overflow occurs when the extra sum bit differs from the ACCWL sign bit.
    function automatic logic sum_ovf(input logic [ACCWL:0] sum);
        return sum[ACCWL] ^ sum[ACCWL-1];
    endfunction

    state_t             state_r;
    state_t             state_nxt;
    logic               gnt_r;
    logic               gnt_nxt;
    logic               ptr_r;
    logic               ptr_nxt;
    logic               rdy0_r;
    logic               rdy1_r;
    logic               res_valid_r;
    logic               busy_r;
    logic [INWL-1:0]    mul1_r;
    logic [INWL-1:0]    mul2_r;
    logic               mv_r;
    logic [ACCWL-1:0]   acc_r;
    logic               sat_r;

    logic               start_s;
    logic               beat_acc_s;
    logic               sel_last_s;
    logic [INWL-1:0]    sel_in1_s;
    logic [INWL-1:0]    sel_in2_s;
    logic [ACCWL:0]     sum_s;

    // A beat is taken only from the requester currently shown READY.
    always_comb begin
        beat_acc_s = (I_REQ0_VALID & rdy0_r) | (I_REQ1_VALID & rdy1_r);
        if (gnt_r) begin
            sel_in1_s  = I_REQ1_IN1;
            sel_in2_s  = I_REQ1_IN2;
            sel_last_s = I_REQ1_LAST;
        end else begin
            sel_in1_s  = I_REQ0_IN1;
            sel_in2_s  = I_REQ0_IN2;
            sel_last_s = I_REQ0_LAST;
        end
    end

    // Next-state logic for the arbiter and vector sequencer.
    always_comb begin
        state_nxt = state_r;
        gnt_nxt   = gnt_r;
        ptr_nxt   = ptr_r;
        start_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (I_REQ0_VALID || I_REQ1_VALID) begin
                    start_s   = 1'b1;
                    state_nxt = ST_RUN;
                    if (I_REQ0_VALID && I_REQ1_VALID) begin
                        // On a tie, grant the requester that was not served last.
                        gnt_nxt = ~ptr_r;
                    end else if (I_REQ0_VALID) begin
                        gnt_nxt = 1'b0;
                    end else begin
                        gnt_nxt = 1'b1;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (beat_acc_s && sel_last_s) begin
                    state_nxt = ST_DRAIN;
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            ST_DRAIN: begin
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (I_RES_READY) begin
                    state_nxt = ST_IDLE;
                    ptr_nxt   = gnt_r;
                end else begin
                    state_nxt = ST_DONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register. The handshake outputs are registered from the next state.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state_r     <= ST_IDLE;
            gnt_r       <= 1'b0;
            ptr_r       <= 1'b1;
            rdy0_r      <= 1'b0;
            rdy1_r      <= 1'b0;
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt;
            gnt_r       <= gnt_nxt;
            ptr_r       <= ptr_nxt;
            rdy0_r      <= (state_nxt == ST_RUN) && !gnt_nxt;
            rdy1_r      <= (state_nxt == ST_RUN) && gnt_nxt;
            res_valid_r <= (state_nxt == ST_DONE);
            busy_r      <= (state_nxt != ST_IDLE);
        end
    end

    // Sign-extend the product, then add it to the accumulator at ACCWL+1 bits.
    always_comb begin
        sum_s = {acc_r[ACCWL-1], acc_r} + {{EXTW{I_MUL_OUT[2*INWL-1]}}, I_MUL_OUT};
    end

    // Operand registers and saturating accumulator. The product of a beat
    // is added one edge after the beat is accepted.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            mul1_r <= {INWL{1'b0}};
            mul2_r <= {INWL{1'b0}};
            mv_r   <= 1'b0;
            acc_r  <= {ACCWL{1'b0}};
            sat_r  <= 1'b0;
        end else if (start_s) begin
            mv_r   <= 1'b0;
            acc_r  <= {ACCWL{1'b0}};
            sat_r  <= 1'b0;
        end else begin
            if (mv_r) begin
                acc_r <= clamp_sum(sum_s);
                sat_r <= sat_r | sum_ovf(sum_s);
            end else begin
                acc_r <= acc_r;
                sat_r <= sat_r;
            end
            mv_r <= beat_acc_s;
            if (beat_acc_s) begin
                mul1_r <= sel_in1_s;
                mul2_r <= sel_in2_s;
            end else begin
                mul1_r <= mul1_r;
                mul2_r <= mul2_r;
            end
        end
    end

    assign O_REQ0_READY = rdy0_r;
    assign O_REQ1_READY = rdy1_r;
    assign O_MUL_IN1    = mul1_r;
    assign O_MUL_IN2    = mul2_r;
    assign O_RES_VALID  = res_valid_r;
    assign O_RES_DATA   = acc_r;
    assign O_RES_ID     = gnt_r;
    assign O_RES_SAT    = sat_r;
    assign O_BUSY       = busy_r;

endmodule

// File: tb/tb_mac_sched.sv
// tb_mac_sched: two instances of mac_sched, one with ACCWL=20 and one with
// ACCWL=16, driven by the same stimulus. A transaction-level model sums each
// accepted beat directly, saturating at each step. Control outputs are
// compared every cycle, and results are compared while DONE.
module tb_mac_sched;

    localparam int INWL = 8;
    localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, v0, l0, v1, l1, rr;
    logic [INWL-1:0] a0, b0, a1, b1;

    logic r0_a, r1_a, rv_a, id_a, st_a, bz_a;
    logic [INWL-1:0] m1_a, m2_a;
    logic [19:0] d_a;
    logic signed [15:0] mo_a;
    logic r0_b, r1_b, rv_b, id_b, st_b, bz_b;
    logic [INWL-1:0] m1_b, m2_b;
    logic [15:0] d_b;
    logic signed [15:0] mo_b;

    assign mo_a = $signed(m1_a) * $signed(m2_a);
    assign mo_b = $signed(m1_b) * $signed(m2_b);

    mac_sched #(.INWL(INWL), .ACCWL(20)) dut_a (
        .I_CLK(clk), .I_RST_N(rst_n),
        .I_REQ0_VALID(v0), .I_REQ0_IN1(a0), .I_REQ0_IN2(b0), .I_REQ0_LAST(l0), .O_REQ0_READY(r0_a),
        .I_REQ1_VALID(v1), .I_REQ1_IN1(a1), .I_REQ1_IN2(b1), .I_REQ1_LAST(l1), .O_REQ1_READY(r1_a),
        .O_MUL_IN1(m1_a), .O_MUL_IN2(m2_a), .I_MUL_OUT(mo_a),
        .O_RES_VALID(rv_a), .O_RES_DATA(d_a), .O_RES_ID(id_a), .O_RES_SAT(st_a),
        .I_RES_READY(rr), .O_BUSY(bz_a)
    );

    mac_sched #(.INWL(INWL), .ACCWL(16)) dut_b (
        .I_CLK(clk), .I_RST_N(rst_n),
        .I_REQ0_VALID(v0), .I_REQ0_IN1(a0), .I_REQ0_IN2(b0), .I_REQ0_LAST(l0), .O_REQ0_READY(r0_b),
        .I_REQ1_VALID(v1), .I_REQ1_IN1(a1), .I_REQ1_IN2(b1), .I_REQ1_LAST(l1), .O_REQ1_READY(r1_b),
        .O_MUL_IN1(m1_b), .O_MUL_IN2(m2_b), .I_MUL_OUT(mo_b),
        .O_RES_VALID(rv_b), .O_RES_DATA(d_b), .O_RES_ID(id_b), .O_RES_SAT(st_b),
        .I_RES_READY(rr), .O_BUSY(bz_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    int m_phase;
    bit m_gnt, m_last;
    int m_acc_a, m_acc_b, m_mul1, m_mul2;
    bit m_sat_a, m_sat_b;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic sat_add(input int acc, input int p, input int w, output int res, output bit ovf);
        int mx, mn, s;
        mx = (1 << (w - 1)) - 1;
        mn = -(1 << (w - 1));
        s = acc + p;
        ovf = 1'b0;
        res = s;
        if (s > mx) begin res = mx; ovf = 1'b1; end
        if (s < mn) begin res = mn; ovf = 1'b1; end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_gnt = 1'b0; m_last = 1'b1;
        m_acc_a = 0; m_acc_b = 0; m_sat_a = 1'b0; m_sat_b = 1'b0;
        m_mul1 = 0; m_mul2 = 0;
    endtask

    // Apply the inputs present at a rising edge to the model.
    task automatic model_edge();
        int x, y, r;
        bit o;
        if (!rst_n) begin
            model_reset();
        end else begin
            case (m_phase)
                P_IDLE: if (v0 || v1) begin
                    if (v0 && v1) m_gnt = !m_last;
                    else m_gnt = v1;
                    m_acc_a = 0; m_acc_b = 0; m_sat_a = 1'b0; m_sat_b = 1'b0;
                    m_phase = P_RUN;
                end
                P_RUN: if (m_gnt ? v1 : v0) begin
                    x = m_gnt ? int'($signed(a1)) : int'($signed(a0));
                    y = m_gnt ? int'($signed(b1)) : int'($signed(b0));
                    m_mul1 = x; m_mul2 = y;
                    sat_add(m_acc_a, x * y, 20, r, o); m_acc_a = r; m_sat_a = m_sat_a | o;
                    sat_add(m_acc_b, x * y, 16, r, o); m_acc_b = r; m_sat_b = m_sat_b | o;
                    if (m_gnt ? l1 : l0) m_phase = P_DRAIN;
                end
                P_DRAIN: m_phase = P_DONE;
                default: if (rr) begin m_last = m_gnt; m_phase = P_IDLE; end
            endcase
        end
    endtask

    task automatic check_all();
        bit run, done;
        run = (m_phase == P_RUN);
        done = (m_phase == P_DONE);
        chk("rdy0_a", int'(r0_a), int'(run && !m_gnt));
        chk("rdy1_a", int'(r1_a), int'(run && m_gnt));
        chk("rdy0_b", int'(r0_b), int'(run && !m_gnt));
        chk("rdy1_b", int'(r1_b), int'(run && m_gnt));
        chk("busy_a", int'(bz_a), int'(m_phase != P_IDLE));
        chk("busy_b", int'(bz_b), int'(m_phase != P_IDLE));
        chk("rvalid_a", int'(rv_a), int'(done));
        chk("rvalid_b", int'(rv_b), int'(done));
        chk("mul1", int'($signed(m1_a)), m_mul1);
        chk("mul2", int'($signed(m2_a)), m_mul2);
        if (done) begin
            chk("data_a", int'($signed(d_a)), m_acc_a);
            chk("sat_a", int'(st_a), int'(m_sat_a));
            chk("id_a", int'(id_a), int'(m_gnt));
            chk("data_b", int'($signed(d_b)), m_acc_b);
            chk("sat_b", int'(st_b), int'(m_sat_b));
            chk("id_b", int'(id_b), int'(m_gnt));
        end
    endtask

    // One clock: the model takes the edge, then the outputs are checked on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic clr_in();
        v0 = 1'b0; l0 = 1'b0; a0 = 8'd0; b0 = 8'd0;
        v1 = 1'b0; l1 = 1'b0; a1 = 8'd0; b1 = 8'd0;
    endtask

    task automatic do_reset();
        clr_in();
        rr = 1'b0;
        rst_n = 1'b0;
        model_reset();
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    // Present one beat on a requester until it is accepted, then drop VALID.
    task automatic beat(input bit req, input int x, input int y, input bit last);
        bit took;
        took = 1'b0;
        for (int i = 0; i < 20 && !took; i++) begin
            if (req) begin v1 = 1'b1; a1 = x[7:0]; b1 = y[7:0]; l1 = last; took = r1_a; end
            else     begin v0 = 1'b1; a0 = x[7:0]; b0 = y[7:0]; l0 = last; took = r0_a; end
            cycle();
        end
        if (!took) chk("beat_timeout", 0, 1);
        if (req) v1 = 1'b0; else v0 = 1'b0;
    endtask

    task automatic wait_result(input int eid, input int ea, input int esa, input int eb, input int esb);
        for (int i = 0; i < 40 && !rv_a; i++) cycle();
        if (!rv_a) begin
            chk("res_timeout", 0, 1);
        end else begin
            chk("res_id", int'(id_a), eid);
            chk("res_data_a", int'($signed(d_a)), ea);
            chk("res_sat_a", int'(st_a), esa);
            chk("res_data_b", int'($signed(d_b)), eb);
            chk("res_sat_b", int'(st_b), esb);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clr_in();
        rr = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Reset state.
        chk("rst_rdy0", int'(r0_a), 0);
        chk("rst_ptr_busy", int'(bz_a), 0);
        chk("rst_data", int'(d_a), 0);

        // Single requester, back-to-back beats.
        rr = 1'b1;
        beat(1'b0, 64, 64, 1'b0);
        beat(1'b0, -32, 16, 1'b0);
        beat(1'b0, 1, 1, 1'b1);
        chk("t1_valid_after_last", int'(rv_a), 0);
        wait_result(0, 3585, 0, 3585, 0);
        cycle();

        // Both requesters valid from reset: alternate without starvation.
        do_reset();
        rr = 1'b1;
        v0 = 1'b1; a0 = 8'd2; b0 = 8'd3; l0 = 1'b1;
        v1 = 1'b1; a1 = 8'd4; b1 = 8'd5; l1 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wait_result(0, 6, 0, 6, 0);
            cycle();
            wait_result(1, 20, 0, 20, 0);
            cycle();
        end
        clr_in();

        // Saturation in the 16-bit instance, then the SAT flag clears.
        beat(1'b0, -128, -128, 1'b0);
        beat(1'b0, -128, -128, 1'b1);
        wait_result(0, 32768, 0, 32767, 1);
        cycle();
        beat(1'b0, 1, 1, 1'b1);
        wait_result(0, 1, 0, 1, 0);
        cycle();

        // Gap of three cycles inside a vector.
        beat(1'b1, 10, 10, 1'b0);
        cycle(); cycle(); cycle();
        beat(1'b1, -5, 2, 1'b1);
        wait_result(1, 90, 0, 90, 0);
        cycle();

        // Result backpressure while both requesters wait.
        rr = 1'b0;
        beat(1'b0, 7, 7, 1'b1);
        v0 = 1'b1; a0 = 8'd2; b0 = 8'd2; l0 = 1'b1;
        v1 = 1'b1; a1 = 8'd1; b1 = 8'd1; l1 = 1'b1;
        wait_result(0, 49, 0, 49, 0);
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("bp_data", int'($signed(d_a)), 49);
            chk("bp_rdy0", int'(r0_a), 0);
            chk("bp_rdy1", int'(r1_a), 0);
            chk("bp_valid", int'(rv_a), 1);
        end
        rr = 1'b1;
        cycle();
        wait_result(1, 1, 0, 1, 0);
        cycle();
        clr_in();

        // Asynchronous reset in the middle of a vector.
        beat(1'b0, 50, 50, 1'b0);
        beat(1'b0, 20, 20, 1'b0);
        chk("pre_rst_busy", int'(bz_a), 1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_rdy0", int'(r0_a), 0);
        chk("arst_busy", int'(bz_a), 0);
        chk("arst_mul1", int'(m1_a), 0);
        chk("arst_data_a", int'(d_a), 0);
        chk("arst_data_b", int'(d_b), 0);
        chk("arst_valid", int'(rv_a), 0);
        chk("arst_sat_id", int'(st_a) + int'(id_a), 0);
        cycle();
        rst_n = 1'b1;
        beat(1'b0, 3, 3, 1'b1);
        wait_result(0, 9, 0, 9, 0);
        cycle();

        // Randomised traffic against the model.
        for (int k = 0; k < 600; k++) begin
            v0 = 1'($urandom_range(0, 1)); a0 = 8'($urandom); b0 = 8'($urandom);
            l0 = ($urandom_range(0, 3) == 0);
            v1 = 1'($urandom_range(0, 1)); a1 = 8'($urandom); b1 = 8'($urandom);
            l1 = ($urandom_range(0, 3) == 0);
            rr = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
